// File: rtl/fpu_pkg.sv
// Shared FP constants: rounding-mode codes, special encodings and exception-flag bit positions.
package fpu_pkg;

  typedef enum logic [2:0] {
    RNe = 3'd0,
    RZ  = 3'd1,
    RD  = 3'd2,
    RU  = 3'd3,
    RNa = 3'd4
  } rm_e;

  localparam logic [31:0] FP_INFP = 32'h7F80_0000;
  localparam logic [31:0] FP_NANQ = 32'h7FC0_0000;

  localparam int FLAG_OV  = 3;
  localparam int FLAG_UN  = 2;
  localparam int FLAG_INV = 1;
  localparam int FLAG_INX = 0;

endpackage

// File: rtl/fp_rsp_fifo.sv
// Response FIFO, first-word-fall-through with a registered head; a push reaches the head two edges later.
// Never stalls the writer: the caller guarantees space; the consumer pops via pop when !empty.
module fp_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 38
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DW-1:0]               din,
  input  logic                        pop,
  output logic [DW-1:0]               dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH+2)-1:0]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+2);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_cnt;
  logic          head_vld;
  logic          pop_ok, load, wr_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop && head_vld;
  // Head register refills from storage whenever it is empty or being drained.
  assign load   = (mem_cnt != '0) && (!head_vld || pop_ok);
  assign wr_en  = push && (mem_cnt != CW'(DEPTH));

  assign count = mem_cnt + CW'(head_vld);
  assign full  = (count >= CW'(DEPTH));
  assign empty = !head_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      head_vld <= 1'b0;
      dout     <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (load) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        dout     <= mem[rd_ptr];
        head_vld <= 1'b1;
      end else if (pop_ok) begin
        head_vld <= 1'b0;
      end
      mem_cnt <= mem_cnt + CW'(wr_en) - CW'(load);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fp_sqr_sched.sv
// Round-robin, credit-gated scheduler sharing one fixed-latency sqrt unit; accept->rsp_valid is LAT+2 edges.
// Issue stops when credits run out, so the non-stallable unit can always deposit its result.
module fp_sqr_sched
  import fpu_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int W     = 32,
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ*3-1:0] req_rm,
  output logic [W-1:0]      unit_in,
  output logic [2:0]        unit_rm,
  output logic              unit_act,
  input  logic [W-1:0]      unit_out,
  input  logic [3:0]        unit_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic [3:0]        rsp_flags,
  output logic              busy
);

  localparam int CRW = $clog2(DEPTH+1);
  localparam int FCW = $clog2(DEPTH+2);
  localparam int DW  = IDW + W + 4;

  logic [CRW-1:0] credits;
  logic [IDW-1:0] rr_ptr, grant, arb_idx, act_id;
  logic           grant_vld, pop;
  logic [LAT-1:0] tag_vld;
  logic [IDW-1:0] tag_id [LAT];
  logic           fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;

  // fifo_full is implied by credits==0; kept as an independent guard on issue.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    arb_idx   = '0;
    if (credits != '0 && !fifo_full) begin
      for (int k = 0; k < NREQ; k++) begin
        arb_idx = IDW'((int'(rr_ptr) + k) % NREQ);
        if (!grant_vld && req_valid[arb_idx]) begin
          grant_vld = 1'b1;
          grant     = arb_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant] = 1'b1;
  end

  assign pop = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit_in  <= '0;
      unit_rm  <= '0;
      unit_act <= 1'b0;
      act_id   <= '0;
      rr_ptr   <= '0;
      credits  <= CRW'(DEPTH);
      busy     <= 1'b0;
    end else begin
      unit_act <= grant_vld;
      if (grant_vld) begin
        unit_in <= req_data[grant*W +: W];
        unit_rm <= req_rm[grant*3 +: 3];
        act_id  <= grant;
        rr_ptr  <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
      end
      credits <= credits - CRW'(grant_vld) + CRW'(pop);
      busy    <= (|tag_vld) || (fifo_count != '0);
    end
  end

  // Tag pipeline mirrors the unit's latency; stage LAT-1 lines up with unit_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= unit_act;
      tag_id[0]  <= act_id;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  fp_rsp_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_vld[LAT-1]),
    .din   ({tag_id[LAT-1], unit_out, unit_flags}),
    .pop   (pop),
    .dout  ({rsp_id, rsp_data, rsp_flags}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;

endmodule

// File: tb/tb_fp_sqr_sched.sv
// Scoreboard bench for fp_sqr_sched: random and directed traffic against a queue/count reference model.
module tb_fp_sqr_sched;
  import fpu_pkg::*;

  localparam int NREQ  = 4;
  localparam int W     = 32;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;
  localparam int IDW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ*3-1:0] req_rm;
  logic [W-1:0]      unit_in, unit_out;
  logic [2:0]        unit_rm;
  logic              unit_act;
  logic [3:0]        unit_flags;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic [3:0]        rsp_flags;
  logic              busy;

  fp_sqr_sched #(.NREQ(NREQ), .W(W), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_rm(req_rm),
    .unit_in(unit_in), .unit_rm(unit_rm), .unit_act(unit_act),
    .unit_out(unit_out), .unit_flags(unit_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in sqrt unit: exact results for the directed operands, a fixed scramble otherwise.
  function automatic logic [35:0] unit_fn(input logic [31:0] x, input logic [2:0] rm);
    logic [31:0] r;
    logic [3:0]  f;
    case (x)
      32'h4080_0000: begin r = 32'h4000_0000; f = 4'b0000; end
      32'hBF80_0000: begin r = FP_NANQ;       f = 4'b0010; end
      32'h7F80_0000: begin r = FP_INFP;       f = 4'b0000; end
      default: begin
        r = {x[15:0] ^ 16'h5A3C, x[31:16]} ^ {29'd0, rm};
        f = x[3:0] ^ {1'b0, rm};
      end
    endcase
    return {r, f};
  endfunction

  logic [35:0] upipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT-1; i > 0; i--) upipe[i] <= upipe[i-1];
    upipe[0] <= unit_act ? unit_fn(unit_in, unit_rm) : {$urandom, 4'($urandom)};
  end
  assign unit_out   = upipe[LAT-1][35:4];
  assign unit_flags = upipe[LAT-1][3:0];

  // Reference model: outstanding = accepted - popped; credits = DEPTH - outstanding.
  logic [IDW+35:0]  exp_q [$];
  int               grant_log [$];
  int               acc_total = 0;
  int               pop_total = 0;
  logic [IDW-1:0]   rr_model = '0;
  logic [NREQ-1:0]  acc_mask = '0;
  logic [NREQ-1:0]  exp_rdy;
  logic [IDW+35:0]  exp_e;
  int               jj;

  always @(posedge clk) begin
    #3;
    if (rst) begin
      exp_rdy = '0;
      if (acc_total - pop_total < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          jj = (int'(rr_model) + k) % NREQ;
          if (exp_rdy == '0 && req_valid[jj]) exp_rdy[jj] = 1'b1;
        end
      end
      chk("req_ready", req_ready, exp_rdy);
      acc_mask = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          exp_q.push_back({IDW'(i), unit_fn(req_data[i*W +: W], req_rm[i*3 +: 3])});
          acc_total++;
          rr_model = IDW'((i + 1) % NREQ);
          grant_log.push_back(i);
        end
      end
    end else begin
      acc_mask = '0;
    end
  end

  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h, nothing outstanding", rsp_id, rsp_data);
      end else if (rsp_ready) begin
        exp_e = exp_q.pop_front();
        chk("rsp_id", rsp_id, exp_e[IDW+35:36]);
        chk("rsp_data", rsp_data, exp_e[35:4]);
        chk("rsp_flags", rsp_flags, exp_e[3:0]);
      end
      if (rsp_ready) pop_total++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    exp_q.delete();
    grant_log.delete();
    acc_total = 0;
    pop_total = 0;
    rr_model  = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    step();
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 9))
      0:       return 32'h4080_0000;
      1:       return 32'hBF80_0000;
      2:       return 32'h7F80_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic send(input int id, input logic [31:0] d, input logic [2:0] rm);
    req_valid[id] = 1'b1;
    req_data[id*W +: W] = d;
    req_rm[id*3 +: 3] = rm;
    for (int t = 0; t < 100; t++) begin
      step();
      if (acc_mask[id]) break;
    end
    chk("send_accept", acc_mask[id], 1'b1);
    req_valid[id] = 1'b0;
  endtask

  // Granted or idle requesters take a fresh operand; waiting ones hold theirs.
  task automatic refresh(input logic [NREQ-1:0] want);
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i] || !req_valid[i]) begin
        req_valid[i] = want[i];
        req_data[i*W +: W] = rand_op();
        req_rm[i*3 +: 3] = 3'($urandom_range(0, 4));
      end
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 200 && (exp_q.size() != 0 || busy); t++) step();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, base;
    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_rm = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_unit_in", unit_in, 0);
    chk("rst_unit_rm", unit_rm, 0);
    chk("rst_unit_act", unit_act, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_word", {rsp_id, rsp_data, rsp_flags}, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // Single request with latency and busy timing.
    rsp_ready = 1'b1;
    send(2, 32'h4080_0000, RNe);
    n = cyc;
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("single_latency", cyc - n, LAT + 2);
    chk("single_id", rsp_id, 2);
    chk("single_data", rsp_data, 32'h4000_0000);
    chk("single_flags", rsp_flags, 4'b0000);
    @(negedge clk);
    chk("single_rsp_gone", rsp_valid, 1'b0);
    chk("single_busy_lag", busy, 1'b1);
    @(negedge clk);
    chk("single_busy_drop", busy, 1'b0);
    step();

    // Round-robin over requesters 0,1,3 from rr_ptr=0.
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && grant_log.size() < 6; c++) begin
      refresh(4'b1011);
      step();
    end
    req_valid = '0;
    chk("rr_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("rr_order", grant_log[i], (i % 3 == 2) ? 3 : i % 3);
    drain();

    // Exceptional operands pass straight through.
    send(1, 32'hBF80_0000, RZ);
    send(3, 32'h7F80_0000, RU);
    drain();

    // Backpressure: credits bound accepts to DEPTH.
    rsp_ready = 1'b0;
    base = acc_total;
    for (int c = 0; c < 20; c++) begin
      refresh(4'b1111);
      step();
    end
    chk("bp_accepts", acc_total - base, DEPTH);
    chk("bp_ready_zero", req_ready, 0);
    rsp_ready = 1'b1;
    refresh(4'b1111);
    step();
    rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      refresh(4'b1111);
      step();
    end
    chk("bp_one_more", acc_total - base, DEPTH + 1);

    // Pop-only cycle, then pop and issue together at credits=1.
    rsp_ready = 1'b1;
    refresh(4'b1111);
    step();
    refresh(4'b1111);
    chk("sim_grant_a", |req_ready, 1'b1);
    step();
    rsp_ready = 1'b0;
    refresh(4'b1111);
    chk("sim_grant_b", |req_ready, 1'b1);
    step();
    for (int c = 0; c < 5; c++) begin
      refresh(4'b1111);
      step();
    end
    chk("sim_accepts", acc_total - base, DEPTH + 3);
    drain();

    // Reset with 2 results queued and 3 operations in flight.
    rsp_ready = 1'b0;
    send(0, $urandom, RNe);
    send(1, $urandom, RD);
    repeat (LAT + 3) step();
    send(2, $urandom, RZ);
    send(3, $urandom, RU);
    send(0, $urandom, RNa);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_unit_act", unit_act, 0);
    chk("mid_rst_unit_in", unit_in, 0);
    chk("mid_rst_rsp_word", {rsp_id, rsp_data, rsp_flags}, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    do_reset();
    rsp_ready = 1'b1;
    repeat (LAT + 4) step();
    send(1, 32'h4080_0000, RNe);
    drain();

    // Randomized traffic with random consumer stalls.
    for (int c = 0; c < 400; c++) begin
      refresh(4'($urandom));
      rsp_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
